// File: rtl/twinstick_pkg.sv
// Shared definitions for the twin-stick input conditioner.
// Contents: joy_dig / analog field positions, direction bit orders,
//           the stage-1 pipeline payload, and direction helper functions.
package twinstick_pkg;

  localparam int unsigned JOY_W = 12;
  localparam int unsigned ANA_W = 16;
  localparam int unsigned DIR_W = 4;

  // joy_dig fields (per player)
  localparam int unsigned JOY_RUN_LSB = 0;
  localparam int unsigned JOY_AIM_LSB = 4;
  localparam int unsigned JOY_FIRE    = 8;

  // Analog word fields (per stick): Y in the high byte, X in the low byte
  localparam int unsigned ANA_X_LSB = 0;
  localparam int unsigned ANA_Y_LSB = 8;

  // Cardinal direction order {U,D,L,R}
  localparam int unsigned IDX_U = 3;
  localparam int unsigned IDX_D = 2;
  localparam int unsigned IDX_L = 1;
  localparam int unsigned IDX_R = 0;

  // Diagonal output order {DL,DR,UL,UR}
  localparam int unsigned IDX_UR = 0;
  localparam int unsigned IDX_UL = 1;
  localparam int unsigned IDX_DR = 2;
  localparam int unsigned IDX_DL = 3;

  // Stage-1 register contents: conditioned inputs plus the controls that travel with them
  typedef struct packed {
    logic [DIR_W-1:0] flag_l;
    logic [DIR_W-1:0] flag_r;
    logic [DIR_W-1:0] dig_run;
    logic [DIR_W-1:0] dig_aim;
    logic             fire;
    logic             tick;
    logic             rotate45;
    logic             aimfire;
    logic             autofire;
  } stage1_t;

  // Combine a cardinal set into the four diagonals
  function automatic logic [DIR_W-1:0] rotate45(input logic [DIR_W-1:0] dir4);
    logic [DIR_W-1:0] d;
    d         = '0;
    d[IDX_UR] = dir4[IDX_U] & dir4[IDX_R];
    d[IDX_DL] = dir4[IDX_D] & dir4[IDX_L];
    d[IDX_UL] = dir4[IDX_U] & dir4[IDX_L];
    d[IDX_DR] = dir4[IDX_D] & dir4[IDX_R];
    return d;
  endfunction

  // Digital switches are already diagonal on rotated cabinets: one switch per diagonal
  function automatic logic [DIR_W-1:0] diag_map(input logic [DIR_W-1:0] sw4);
    logic [DIR_W-1:0] d;
    d         = '0;
    d[IDX_UR] = sw4[IDX_U];
    d[IDX_DL] = sw4[IDX_D];
    d[IDX_UL] = sw4[IDX_L];
    d[IDX_DR] = sw4[IDX_R];
    return d;
  endfunction

  // Opposing switches cancel each other
  function automatic logic [DIR_W-1:0] socd_clean(input logic [DIR_W-1:0] dir4);
    logic [DIR_W-1:0] d;
    d = dir4;
    if (dir4[IDX_U] && dir4[IDX_D]) begin
      d[IDX_U] = 1'b0;
      d[IDX_D] = 1'b0;
    end
    if (dir4[IDX_L] && dir4[IDX_R]) begin
      d[IDX_L] = 1'b0;
      d[IDX_R] = 1'b0;
    end
    return d;
  endfunction

endpackage

// File: rtl/twinstick_channel.sv
// One player of the twin-stick conditioner; holds all per-player state.
// Ports:
//   i_clk, i_reset          clock and synchronous active-high reset
//   i_tick                  one-cycle timebase strobe
//   i_cfg_*                 rotate45 / aim-fire / autofire mode selects
//   i_joy_dig               digital run [3:0], aim [7:4], fire [8]
//   i_ana_l, i_ana_r        move / aim sticks, {Y,X} signed bytes
//   o_run, o_aim, o_fire    registered core inputs (2-cycle latency)
module twinstick_channel
  import twinstick_pkg::*;
#(
  parameter int          THRESH_ON  = 20,
  parameter int          THRESH_OFF = 12,
  parameter int unsigned HOLD_TICKS = 8,
  parameter int unsigned AF_PERIOD  = 4
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic             i_tick,
  input  logic             i_cfg_rotate45,
  input  logic             i_cfg_aimfire,
  input  logic             i_cfg_autofire,
  input  logic [JOY_W-1:0] i_joy_dig,
  input  logic [ANA_W-1:0] i_ana_l,
  input  logic [ANA_W-1:0] i_ana_r,
  output logic [DIR_W-1:0] o_run,
  output logic [DIR_W-1:0] o_aim,
  output logic             o_fire
);

  localparam int unsigned HOLD_W = (HOLD_TICKS < 1) ? 1 : $clog2(HOLD_TICKS + 1);
  localparam int unsigned AF_W   = (AF_PERIOD < 2) ? 1 : $clog2(AF_PERIOD);

  // Thresholds as 9-bit signed so that -128 compares without overflow
  localparam logic signed [8:0] ON_P  = 9'(THRESH_ON);
  localparam logic signed [8:0] OFF_P = 9'(THRESH_OFF);
  localparam logic signed [8:0] ON_N  = -ON_P;
  localparam logic signed [8:0] OFF_N = -OFF_P;

  function automatic logic neg_flag(input logic signed [8:0] v, input logic cur);
    logic f;
    f = cur;
    if (v < ON_N)       f = 1'b1;
    else if (v > OFF_N) f = 1'b0;
    return f;
  endfunction

  function automatic logic pos_flag(input logic signed [8:0] v, input logic cur);
    logic f;
    f = cur;
    if (v > ON_P)       f = 1'b1;
    else if (v < OFF_P) f = 1'b0;
    return f;
  endfunction

  // Negative Y is up, negative X is left
  function automatic logic [DIR_W-1:0] stick_flags(input logic [ANA_W-1:0] ana,
                                                   input logic [DIR_W-1:0] cur);
    logic signed [8:0] y;
    logic signed [8:0] x;
    logic [DIR_W-1:0]  f;
    y        = {ana[ANA_Y_LSB+7], ana[ANA_Y_LSB +: 8]};
    x        = {ana[ANA_X_LSB+7], ana[ANA_X_LSB +: 8]};
    f        = '0;
    f[IDX_U] = neg_flag(y, cur[IDX_U]);
    f[IDX_D] = pos_flag(y, cur[IDX_D]);
    f[IDX_L] = neg_flag(x, cur[IDX_L]);
    f[IDX_R] = pos_flag(x, cur[IDX_R]);
    return f;
  endfunction

  stage1_t           r_s1;
  stage1_t           w_s1_nxt;
  logic [DIR_W-1:0]  r_run;
  logic [DIR_W-1:0]  r_aim;
  logic              r_fire;
  logic              r_aim_prev;
  logic              r_req_prev;
  logic [HOLD_W-1:0] r_hold;
  logic              r_phase;
  logic [AF_W-1:0]   r_af_cnt;

  logic [DIR_W-1:0]  w_run;
  logic [DIR_W-1:0]  w_aim;
  logic              w_aim_any;
  logic              w_aim_fall;
  logic [HOLD_W-1:0] w_hold_nxt;
  logic              w_fire_req;
  logic              w_req_rise;
  logic              w_phase_nxt;
  logic [AF_W-1:0]   w_cnt_nxt;
  logic              w_fire_nxt;
  logic              w_unused;

  assign w_unused = &{1'b0, i_joy_dig[JOY_W-1:JOY_FIRE+1]};

  // Stage 1: hysteresis flags, SOCD cleaning, capture of controls
  always_comb begin
    w_s1_nxt          = '0;
    w_s1_nxt.flag_l   = stick_flags(i_ana_l, r_s1.flag_l);
    w_s1_nxt.flag_r   = stick_flags(i_ana_r, r_s1.flag_r);
    w_s1_nxt.dig_run  = socd_clean(i_joy_dig[JOY_RUN_LSB +: DIR_W]);
    w_s1_nxt.dig_aim  = i_joy_dig[JOY_AIM_LSB +: DIR_W];
    w_s1_nxt.fire     = i_joy_dig[JOY_FIRE];
    w_s1_nxt.tick     = i_tick;
    w_s1_nxt.rotate45 = i_cfg_rotate45;
    w_s1_nxt.aimfire  = i_cfg_aimfire;
    w_s1_nxt.autofire = i_cfg_autofire;
  end

  // Stage 2a: run source select and rotation; digital aim shares the run mapping
  always_comb begin
    w_run = '0;
    w_aim = '0;
    if (r_s1.rotate45) begin
      w_run = (|r_s1.flag_l) ? rotate45(r_s1.flag_l) : diag_map(r_s1.dig_run);
      w_aim = rotate45(r_s1.flag_r) | diag_map(r_s1.dig_aim);
    end else begin
      w_run = (|r_s1.flag_l) ? r_s1.flag_l : r_s1.dig_run;
      w_aim = r_s1.flag_r | r_s1.dig_aim;
    end
  end

  // Stage 2b: aim-fire hold and autofire; state-changing events take priority over tick
  always_comb begin
    w_hold_nxt  = r_hold;
    w_phase_nxt = r_phase;
    w_cnt_nxt   = r_af_cnt;
    w_aim_any   = |w_aim;
    w_aim_fall  = r_aim_prev & ~w_aim_any;

    if (!r_s1.aimfire || w_aim_any) begin
      w_hold_nxt = '0;
    end else if (w_aim_fall) begin
      w_hold_nxt = HOLD_W'(HOLD_TICKS);
    end else if (r_s1.tick && (r_hold != '0)) begin
      w_hold_nxt = r_hold - HOLD_W'(1);
    end

    // Using the next hold value keeps fire continuous across the aim release
    w_fire_req = r_s1.aimfire ? (w_aim_any | (w_hold_nxt != '0)) : r_s1.fire;
    w_req_rise = w_fire_req & ~r_req_prev;

    if (!r_s1.autofire || !w_fire_req) begin
      w_phase_nxt = 1'b0;
      w_cnt_nxt   = '0;
    end else if (w_req_rise) begin
      w_phase_nxt = 1'b1;
      w_cnt_nxt   = '0;
    end else if (r_s1.tick) begin
      if (r_af_cnt == AF_W'(AF_PERIOD - 1)) begin
        w_cnt_nxt   = '0;
        w_phase_nxt = ~r_phase;
      end else begin
        w_cnt_nxt = r_af_cnt + AF_W'(1);
      end
    end

    w_fire_nxt = r_s1.autofire ? (w_fire_req & w_phase_nxt) : w_fire_req;
  end

  // Pipeline and per-player state registers
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_s1       <= '0;
      r_run      <= '0;
      r_aim      <= '0;
      r_fire     <= 1'b0;
      r_aim_prev <= 1'b0;
      r_req_prev <= 1'b0;
      r_hold     <= '0;
      r_phase    <= 1'b0;
      r_af_cnt   <= '0;
    end else begin
      r_s1       <= w_s1_nxt;
      r_run      <= w_run;
      r_aim      <= w_aim;
      r_fire     <= w_fire_nxt;
      r_aim_prev <= w_aim_any;
      r_req_prev <= w_fire_req;
      r_hold     <= w_hold_nxt;
      r_phase    <= w_phase_nxt;
      r_af_cnt   <= w_cnt_nxt;
    end
  end

  assign o_run  = r_run;
  assign o_aim  = r_aim;
  assign o_fire = r_fire;

endmodule

// File: rtl/twinstick_mapper.sv
// Multi-player twin-stick input conditioner between hps_io and a Williams-2 core.
// Ports:
//   clk_sys, reset          system clock, synchronous active-high reset
//   tick                    timebase strobe (vblank start)
//   cfg_rotate45/aimfire/autofire   mode selects shared by all players
//   joy_dig                 NUM_PLAYERS x 12 digital inputs
//   ana_l, ana_r            NUM_PLAYERS x 16 analog sticks
//   run_out, aim_out        NUM_PLAYERS x 4 core directions
//   fire_out                NUM_PLAYERS triggers
module twinstick_mapper
  import twinstick_pkg::*;
#(
  parameter int unsigned NUM_PLAYERS = 2,
  parameter int          THRESH_ON   = 20,
  parameter int          THRESH_OFF  = 12,
  parameter int unsigned HOLD_TICKS  = 8,
  parameter int unsigned AF_PERIOD   = 4
) (
  input  logic                           clk_sys,
  input  logic                           reset,
  input  logic                           tick,
  input  logic                           cfg_rotate45,
  input  logic                           cfg_aimfire,
  input  logic                           cfg_autofire,
  input  logic [NUM_PLAYERS*JOY_W-1:0]   joy_dig,
  input  logic [NUM_PLAYERS*ANA_W-1:0]   ana_l,
  input  logic [NUM_PLAYERS*ANA_W-1:0]   ana_r,
  output logic [NUM_PLAYERS*DIR_W-1:0]   run_out,
  output logic [NUM_PLAYERS*DIR_W-1:0]   aim_out,
  output logic [NUM_PLAYERS-1:0]         fire_out
);

  // Parameter sanity
  if (THRESH_OFF > THRESH_ON) begin : g_bad_thresh
    $error("twinstick_mapper: THRESH_OFF must not exceed THRESH_ON");
  end
  if ((NUM_PLAYERS < 1) || (NUM_PLAYERS > 4)) begin : g_bad_players
    $error("twinstick_mapper: NUM_PLAYERS must be 1..4");
  end
  if (AF_PERIOD < 1) begin : g_bad_af
    $error("twinstick_mapper: AF_PERIOD must be at least 1");
  end

  // One independent channel per player
  for (genvar p = 0; p < NUM_PLAYERS; p++) begin : g_player
    twinstick_channel #(
      .THRESH_ON  (THRESH_ON),
      .THRESH_OFF (THRESH_OFF),
      .HOLD_TICKS (HOLD_TICKS),
      .AF_PERIOD  (AF_PERIOD)
    ) u_channel (
      .i_clk          (clk_sys),
      .i_reset        (reset),
      .i_tick         (tick),
      .i_cfg_rotate45 (cfg_rotate45),
      .i_cfg_aimfire  (cfg_aimfire),
      .i_cfg_autofire (cfg_autofire),
      .i_joy_dig      (joy_dig[p*JOY_W +: JOY_W]),
      .i_ana_l        (ana_l[p*ANA_W +: ANA_W]),
      .i_ana_r        (ana_r[p*ANA_W +: ANA_W]),
      .o_run          (run_out[p*DIR_W +: DIR_W]),
      .o_aim          (aim_out[p*DIR_W +: DIR_W]),
      .o_fire         (fire_out[p])
    );
  end

endmodule

// File: tb/tb_twinstick_mapper.sv
module tb_twinstick_mapper;

  logic        clk_sys = 1'b0;
  logic        reset;
  logic        tick;
  logic        cfg_rotate45;
  logic        cfg_aimfire;
  logic        cfg_autofire;
  logic [47:0] joy_dig;
  logic [63:0] ana_l;
  logic [63:0] ana_r;
  logic [15:0] run_out;
  logic [15:0] aim_out;
  logic [3:0]  fire_out;

  int tests_run    = 0;
  int tests_failed = 0;

  twinstick_mapper #(
    .NUM_PLAYERS (4),
    .THRESH_ON   (20),
    .THRESH_OFF  (12),
    .HOLD_TICKS  (8),
    .AF_PERIOD   (4)
  ) dut (
    .clk_sys      (clk_sys),
    .reset        (reset),
    .tick         (tick),
    .cfg_rotate45 (cfg_rotate45),
    .cfg_aimfire  (cfg_aimfire),
    .cfg_autofire (cfg_autofire),
    .joy_dig      (joy_dig),
    .ana_l        (ana_l),
    .ana_r        (ana_r),
    .run_out      (run_out),
    .aim_out      (aim_out),
    .fire_out     (fire_out)
  );

  always #5 clk_sys = ~clk_sys;

  task automatic step(input int n);
    repeat (n) @(posedge clk_sys);
    #1;
  endtask

  task automatic tick_settle();
    tick = 1'b1;
    step(1);
    tick = 1'b0;
    step(2);
  endtask

  task automatic neutral();
    joy_dig = '0;
    ana_l   = '0;
    ana_r   = '0;
    tick    = 1'b0;
  endtask

  task automatic test_reset();
    reset        = 1'b1;
    tick         = 1'b1;
    cfg_rotate45 = 1'b1;
    cfg_aimfire  = 1'b1;
    cfg_autofire = 1'b1;
    joy_dig      = '1;
    ana_l        = {4{16'h9C9C}};
    ana_r        = {4{16'h9C9C}};
    step(3);
    tests_run++;
    if (run_out !== 16'h0) begin tests_failed++; $display("FAIL reset_run: got %h expected 0000", run_out); end
    tests_run++;
    if (aim_out !== 16'h0) begin tests_failed++; $display("FAIL reset_aim: got %h expected 0000", aim_out); end
    tests_run++;
    if (fire_out !== 4'h0) begin tests_failed++; $display("FAIL reset_fire: got %b expected 0000", fire_out); end
    reset        = 1'b0;
    neutral();
    cfg_rotate45 = 1'b0;
    cfg_aimfire  = 1'b0;
    cfg_autofire = 1'b0;
    joy_dig[11:0] = 12'h101;
    step(1);
    tests_run++;
    if ({run_out[3:0], fire_out[0]} !== 5'b0000_0) begin
      tests_failed++; $display("FAIL release_cycle1: got run=%b fire=%b expected 0000/0", run_out[3:0], fire_out[0]);
    end
    step(1);
    tests_run++;
    if ({run_out[3:0], fire_out[0]} !== 5'b0001_1) begin
      tests_failed++; $display("FAIL release_cycle2: got run=%b fire=%b expected 0001/1", run_out[3:0], fire_out[0]);
    end
    neutral();
    step(3);
  endtask

  task automatic test_hysteresis();
    logic [7:0]  ys [5];
    logic [3:0]  exp_run [5];
    ys = '{8'hEB, 8'hF3, 8'hF5, 8'hF3, 8'h80};
    exp_run = '{4'b0001, 4'b0001, 4'b0000, 4'b0000, 4'b0001};
    cfg_rotate45 = 1'b1;
    for (int i = 0; i < 5; i++) begin
      ana_l[15:0] = {ys[i], 8'h19};
      step(2);
      tests_run++;
      if (run_out[3:0] !== exp_run[i]) begin
        tests_failed++; $display("FAIL hyst_step%0d: run_out=%b expected %b", i, run_out[3:0], exp_run[i]);
      end
    end
    cfg_rotate45 = 1'b0;
    step(2);
    tests_run++;
    if (run_out[3:0] !== 4'b1001) begin tests_failed++; $display("FAIL hyst_min_cardinal: run_out=%b expected 1001", run_out[3:0]); end
    neutral();
    step(3);
  endtask

  task automatic test_source_socd();
    cfg_rotate45 = 1'b0;
    joy_dig[11:0] = 12'h00C;
    step(2);
    tests_run++;
    if (run_out[3:0] !== 4'b0000) begin tests_failed++; $display("FAIL socd_ud: run_out=%b expected 0000", run_out[3:0]); end
    ana_l[15:0] = 16'h009C;
    step(2);
    tests_run++;
    if (run_out[3:0] !== 4'b0010) begin tests_failed++; $display("FAIL analog_priority: run_out=%b expected 0010", run_out[3:0]); end
    ana_l[15:0] = 16'h0000;
    joy_dig[11:0] = 12'h008;
    cfg_rotate45 = 1'b1;
    step(2);
    tests_run++;
    if (run_out[3:0] !== 4'b0001) begin tests_failed++; $display("FAIL dig_rot_u: run_out=%b expected 0001", run_out[3:0]); end
    cfg_rotate45 = 1'b0;
    joy_dig[11:0] = 12'h00A;
    step(2);
    tests_run++;
    if (run_out[3:0] !== 4'b1010) begin tests_failed++; $display("FAIL dig_ul: run_out=%b expected 1010", run_out[3:0]); end
    joy_dig[11:0] = 12'h003;
    step(2);
    tests_run++;
    if (run_out[3:0] !== 4'b0000) begin tests_failed++; $display("FAIL socd_lr: run_out=%b expected 0000", run_out[3:0]); end
    neutral();
    step(3);
  endtask

  task automatic test_aim();
    joy_dig[11:0] = 12'h010;
    cfg_rotate45 = 1'b1;
    step(2);
    tests_run++;
    if (aim_out[3:0] !== 4'b0100) begin tests_failed++; $display("FAIL aim_dig_rot: aim_out=%b expected 0100", aim_out[3:0]); end
    cfg_rotate45 = 1'b0;
    step(2);
    tests_run++;
    if (aim_out[3:0] !== 4'b0001) begin tests_failed++; $display("FAIL aim_dig_card: aim_out=%b expected 0001", aim_out[3:0]); end
    joy_dig[11:0] = 12'h000;
    ana_r[15:0] = 16'hCECE;
    cfg_rotate45 = 1'b1;
    step(2);
    tests_run++;
    if (aim_out[3:0] !== 4'b0010) begin tests_failed++; $display("FAIL aim_ana_rot: aim_out=%b expected 0010", aim_out[3:0]); end
    cfg_rotate45 = 1'b0;
    step(2);
    tests_run++;
    if (aim_out[3:0] !== 4'b1010) begin tests_failed++; $display("FAIL aim_ana_card: aim_out=%b expected 1010", aim_out[3:0]); end
    neutral();
    step(3);
  endtask

  task automatic test_aimfire_hold();
    logic exp_f;
    cfg_aimfire = 1'b1;
    step(2);
    tests_run++;
    if (fire_out[0] !== 1'b0) begin tests_failed++; $display("FAIL af_idle: fire_out=%b expected 0", fire_out[0]); end
    joy_dig[11:0] = 12'h010;
    step(2);
    for (int k = 0; k < 5; k++) tick_settle();
    tests_run++;
    if (fire_out[0] !== 1'b1) begin tests_failed++; $display("FAIL af_aiming: fire_out=%b expected 1", fire_out[0]); end
    joy_dig[11:0] = 12'h000;
    step(2);
    tests_run++;
    if (fire_out[0] !== 1'b1) begin tests_failed++; $display("FAIL af_release: fire_out=%b expected 1", fire_out[0]); end
    for (int k = 1; k <= 8; k++) begin
      tick_settle();
      exp_f = (k < 8);
      tests_run++;
      if (fire_out[0] !== exp_f) begin tests_failed++; $display("FAIL af_hold_tick%0d: fire_out=%b expected %b", k, fire_out[0], exp_f); end
    end
    // Re-aim partway into a hold, then release for a fresh full hold
    joy_dig[11:0] = 12'h010;
    step(2);
    joy_dig[11:0] = 12'h000;
    step(2);
    for (int k = 0; k < 3; k++) tick_settle();
    joy_dig[11:0] = 12'h010;
    step(2);
    for (int k = 0; k < 10; k++) tick_settle();
    tests_run++;
    if (fire_out[0] !== 1'b1) begin tests_failed++; $display("FAIL af_reaim: fire_out=%b expected 1", fire_out[0]); end
    joy_dig[11:0] = 12'h000;
    step(2);
    for (int k = 0; k < 7; k++) tick_settle();
    tests_run++;
    if (fire_out[0] !== 1'b1) begin tests_failed++; $display("FAIL af_rehold7: fire_out=%b expected 1", fire_out[0]); end
    tick_settle();
    tests_run++;
    if (fire_out[0] !== 1'b0) begin tests_failed++; $display("FAIL af_rehold8: fire_out=%b expected 0", fire_out[0]); end
    // Toggling aim-fire mode discards a pending hold
    joy_dig[11:0] = 12'h010;
    step(2);
    joy_dig[11:0] = 12'h000;
    step(2);
    cfg_aimfire = 1'b0;
    step(2);
    tests_run++;
    if (fire_out[0] !== 1'b0) begin tests_failed++; $display("FAIL af_mode_off: fire_out=%b expected 0", fire_out[0]); end
    cfg_aimfire = 1'b1;
    step(2);
    tests_run++;
    if (fire_out[0] !== 1'b0) begin tests_failed++; $display("FAIL af_hold_cleared: fire_out=%b expected 0", fire_out[0]); end
    cfg_aimfire = 1'b0;
    neutral();
    step(3);
  endtask

  task automatic test_autofire();
    logic [19:0] pat;
    pat = 20'b1111_0000_1111_0000_1111;
    cfg_autofire = 1'b1;
    joy_dig[11:0] = 12'h100;
    step(2);
    for (int i = 0; i < 20; i++) begin
      tests_run++;
      if (fire_out[0] !== pat[19-i]) begin tests_failed++; $display("FAIL auto_pat%0d: fire_out=%b expected %b", i, fire_out[0], pat[19-i]); end
      tick_settle();
    end
    joy_dig[11:0] = 12'h000;
    step(2);
    tests_run++;
    if (fire_out[0] !== 1'b0) begin tests_failed++; $display("FAIL auto_release: fire_out=%b expected 0", fire_out[0]); end
    joy_dig[11:0] = 12'h100;
    step(2);
    tests_run++;
    if (fire_out[0] !== 1'b1) begin tests_failed++; $display("FAIL auto_repress: fire_out=%b expected 1", fire_out[0]); end
    // Press coincident with a tick: the restart must ignore that tick
    joy_dig[11:0] = 12'h000;
    step(3);
    joy_dig[11:0] = 12'h100;
    tick = 1'b1;
    step(1);
    tick = 1'b0;
    step(1);
    for (int k = 0; k < 3; k++) tick_settle();
    tests_run++;
    if (fire_out[0] !== 1'b1) begin tests_failed++; $display("FAIL auto_coinc3: fire_out=%b expected 1", fire_out[0]); end
    tick_settle();
    tests_run++;
    if (fire_out[0] !== 1'b0) begin tests_failed++; $display("FAIL auto_coinc4: fire_out=%b expected 0", fire_out[0]); end
    cfg_autofire = 1'b0;
    step(2);
    tests_run++;
    if (fire_out[0] !== 1'b1) begin tests_failed++; $display("FAIL auto_off: fire_out=%b expected 1", fire_out[0]); end
    neutral();
    step(3);
  endtask

  task automatic test_isolation();
    cfg_rotate45 = 1'b0;
    cfg_aimfire  = 1'b1;
    cfg_autofire = 1'b0;
    joy_dig[35:24] = 12'h019;
    step(2);
    tests_run++;
    if ({run_out[11:8], aim_out[11:8], fire_out[2]} !== 9'b1001_0001_1) begin
      tests_failed++; $display("FAIL iso_p2: run=%b aim=%b fire=%b expected 1001/0001/1", run_out[11:8], aim_out[11:8], fire_out[2]);
    end
    tests_run++;
    if ({run_out[15:12], run_out[7:0], aim_out[15:12], aim_out[7:0], fire_out[3], fire_out[1:0]} !== 27'h0) begin
      tests_failed++; $display("FAIL iso_others: run=%h aim=%h fire=%b expected 0", run_out, aim_out, fire_out);
    end
    // Aim release and tick in the same cycle: the fresh hold keeps its full count
    joy_dig[35:24] = 12'h009;
    tick = 1'b1;
    step(1);
    tick = 1'b0;
    step(1);
    for (int k = 0; k < 7; k++) tick_settle();
    tests_run++;
    if (fire_out[2] !== 1'b1) begin tests_failed++; $display("FAIL iso_coinc7: fire_out=%b expected 1", fire_out[2]); end
    tick_settle();
    tests_run++;
    if (fire_out[2] !== 1'b0) begin tests_failed++; $display("FAIL iso_coinc8: fire_out=%b expected 0", fire_out[2]); end
    tests_run++;
    if ({fire_out[3], fire_out[1:0], aim_out[15:12], aim_out[7:0]} !== 15'h0) begin
      tests_failed++; $display("FAIL iso_others_end: aim=%h fire=%b expected 0", aim_out, fire_out);
    end
    neutral();
    step(3);
  endtask

  initial begin
    test_reset();
    test_hysteresis();
    test_source_socd();
    test_aim();
    test_aimfire_hold();
    test_autofire();
    test_isolation();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
